tdm_demux_1ton: RTL
===================

# tdm_demux_1ton

Time-division demultiplexer: the receive-side counterpart of the 2^n-to-1 multiplexer. It takes a serial 1-bit sample stream and distributes consecutive valid samples across `n` output channels in slot order. It presents each completed frame as a registered `n`-bit word with a one-cycle strobe. It sits after a mux-based TDM serializer and restores the parallel channel view, with frame alignment, error flagging and lock indication.

## Interface

**Parameters**
- `n`, default 4: number of channels (slots per frame); legal range n ≥ 2, not required to be a power of two.
- `logn`, default `$clog2(n)`: slot index width.

**Ports**
- `clk`  input  1  — single clock; all state updates on the rising edge.
- `reset`  input  1  — asynchronous, active-high reset.
- `inDemux`  input  1  — serial sample.
- `inValid`  input  1  — `inDemux` carries a sample this cycle.
- `frameSync`  input  1  — when high with `inValid`, this sample is slot 0 of a new frame; ignored without `inValid`.
- `outDemux`  output  n  — last completed frame; bit k holds the slot-k sample; registered, held between frames.
- `outValid`  output  1  — one-cycle pulse: `outDemux` updated this cycle.
- `slot`  output  logn  — index the next valid sample will be written to.
- `locked`  output  1  — high in RUN state.
- `frameErr`  output  1  — one-cycle pulse: frameSync arrived mid-frame.

## Operation

- **States**
  - IDLE: no frame alignment.
  - RUN: aligned, collecting slots.
- **IDLE**
  - Samples without `frameSync` are discarded.
  - `inValid && frameSync`: sample stored to shadow bit 0, `slot`←1, go to RUN.
- **RUN, `inValid && !frameSync`**
  - Sample stored to shadow[`slot`].
  - If `slot == n-1`: `outDemux` ← shadow with bit n-1 = sample, `outValid` pulse, `slot`←0.
  - Otherwise `slot` increments.
  - Wrap is explicit at n-1, so non-power-of-two `n` never reaches indices ≥ n.
- **RUN, `inValid && frameSync` with `slot == 0`**: normal slot-0 capture, no error.
- **RUN, `inValid && frameSync` with `slot != 0`**
  - Partial frame discarded; `outDemux` unchanged, no `outValid`.
  - `frameErr` pulses.
  - Sample taken as slot 0, `slot`←1, stay in RUN.
- **No `inValid`**: cycles without `inValid` hold all state; gaps inside a frame are legal and unbounded.
- **Shadow contents**: bits of an abandoned partial frame are never exposed; `outDemux` changes only on frame completion.
- **`n == 2`**: a frameSync sample followed by one non-sync sample completes a frame.

## Timing

- **Reset values** (asynchronous, immediate): `outDemux`=0, `outValid`=0, `frameErr`=0, `slot`=0, `locked`=0, state IDLE, shadow cleared.
- **Reset mid-frame**: partial frame lost, no `outValid`, must re-sync.
- **Latency**: the slot n-1 sample is sampled on edge E; `outDemux`/`outValid` are valid after E for exactly one cycle of `outValid`.
- **Back-to-back frames**: a frame can complete every n cycles with continuous `inValid`.
- **`frameErr`** asserts after the edge that sampled the offending `frameSync`, for one cycle.
- **`locked`** rises after the edge that takes the first sync sample. It stays high until reset; errors re-align rather than unlock.
- **`slot`** reflects the registered counter, updated on the same edge as the capture.
- All outputs are registered; no combinational input-to-output path.

## Structure

- **Shared package `tdm_pkg`**
  - State encoding constants `ST_IDLE`=0, `ST_RUN`=1.
  - Minimum channel count constant `TDM_MIN_N`=2.
  - The same package serves the future serializer side.
- **Sub-module `mod_n_counter`**
  - Parameters `n`, `logn`; inputs `clk`, `reset`, `en`, `load0`.
  - Output `count`; output `wrap` asserted when `en && count == n-1`.
  - Instantiated once as the slot counter.
- Top level holds the FSM, shadow register and output registers.

## Test plan

- **Reset values**: reset asserted mid-sim with `slot`=2 → all outputs 0 immediately, `locked`=0; the following non-sync samples are ignored.
- **Basic frame, n=4**: sync+1, 0, 1, 1 on consecutive cycles → `outDemux`=4'b1101, `outValid` high one cycle after the 4th sample, `slot`=0.
- **Gaps and back-to-back frames**: frame 1, 0, 0, 1 with 3 idle cycles between samples, then frame 0, 1, 1, 0 immediately after → `outDemux`=4'b1001 then 4'b0110, two `outValid` pulses, no `frameErr`.
- **Mid-frame sync**: sync+1, 1, then sync+0, 1, 1, 1 → `frameErr` pulse after the 3rd sample, single `outValid` with `outDemux`=4'b1110, `locked` stays 1.
- **Non-power-of-two n=3**: sync+1, 0, 1 repeated 3 times → `slot` cycles 1, 2, 0 only; `outDemux`=3'b101 each frame.
- **Sync without valid**: `frameSync`=1, `inValid`=0 in IDLE and in RUN at `slot`=2 → no state change, no `frameErr`.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared TDM definitions for the demultiplexer and the future serializer side.
//   tdmState_t : frame-alignment state (ST_IDLE = not aligned, ST_RUN = aligned)
//   TDM_MIN_N  : smallest legal channel count
package tdm_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tdmState_t;

    localparam int unsigned TDM_MIN_N = 2;

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-n slot counter.
//   clk, reset : clock, asynchronous active-high reset
//   en         : advance the count this cycle
//   load0      : restart the frame at slot 0; together with en the slot-0
//                sample is consumed, so the count lands on 1
//   count      : current slot index, 0 .. n-1
//   wrap       : en while count == n-1 (last slot of the frame consumed)
module mod_n_counter #(
    parameter int unsigned n    = 4,
    parameter int unsigned logn = $clog2(n)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            load0,
    output logic [logn-1:0] count,
    output logic            wrap
);

    localparam logic [logn-1:0] LAST = logn'(n - 1);

    assign wrap = en && (count == LAST);

    // Explicit wrap at n-1 keeps non-power-of-two n inside 0 .. n-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load0) begin
            count <= en ? logn'(1) : '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux_1ton.sv
// Time-division demultiplexer: spreads a serial sample stream over n slots
// and presents each completed frame as a registered n-bit word.
//   clk, reset : clock, asynchronous active-high reset
//   inDemux    : serial sample
//   inValid    : inDemux carries a sample this cycle
//   frameSync  : with inValid, this sample is slot 0 of a new frame
//   outDemux   : last completed frame, bit k = slot k sample
//   outValid   : one-cycle pulse when outDemux is updated
//   slot       : slot index the next valid sample will be written to
//   locked     : frame alignment acquired (stays high until reset)
//   frameErr   : one-cycle pulse when frameSync arrived mid-frame
module tdm_demux_1ton
    import tdm_pkg::*;
#(
    parameter int unsigned n    = 4,
    parameter int unsigned logn = $clog2(n)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inDemux,
    input  logic            inValid,
    input  logic            frameSync,
    output logic [n-1:0]    outDemux,
    output logic            outValid,
    output logic [logn-1:0] slot,
    output logic            locked,
    output logic            frameErr
);

    tdmState_t      state;
    tdmState_t      nextState;
    logic [n-1:0]   shadow;
    logic [n-1:0]   shadowNext;
    logic           cntEn;
    logic           cntLoad0;
    logic           slotWrap;
    logic           frameDone;
    logic           syncErr;

    mod_n_counter #(
        .n    (n),
        .logn (logn)
    ) slotCounter (
        .clk   (clk),
        .reset (reset),
        .en    (cntEn),
        .load0 (cntLoad0),
        .count (slot),
        .wrap  (slotWrap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState  = state;
        cntEn      = 1'b0;
        cntLoad0   = 1'b0;
        shadowNext = shadow;
        frameDone  = 1'b0;
        syncErr    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (inValid && frameSync) begin
                    nextState     = ST_RUN;
                    cntEn         = 1'b1;
                    cntLoad0      = 1'b1;
                    shadowNext[0] = inDemux;
                end
            end
            ST_RUN: begin
                if (inValid) begin
                    cntEn = 1'b1;
                    if (frameSync) begin
                        // Re-align: a partial frame is dropped silently except
                        // for the error pulse; stale shadow bits are always
                        // overwritten before the next completed frame.
                        cntLoad0      = 1'b1;
                        syncErr       = (slot != '0);
                        shadowNext[0] = inDemux;
                    end else begin
                        shadowNext[slot] = inDemux;
                        frameDone        = slotWrap;
                    end
                end
            end
            default: nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow   <= '0;
            outDemux <= '0;
            outValid <= 1'b0;
            frameErr <= 1'b0;
        end else begin
            shadow   <= shadowNext;
            outValid <= frameDone;
            frameErr <= syncErr;
            if (frameDone) begin
                outDemux <= shadowNext;
            end
        end
    end

    assign locked = (state == ST_RUN);

endmodule
